// File: rtl/ias_pkg.sv
// rtl/ias_pkg.sv - shared IAS word/byte constants, reader state enum and field helpers
package ias_pkg;

  localparam int WORD_W         = 40;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 5;
  localparam int LANE_W         = 3;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  // Left instruction occupies the upper half of the word, right instruction the lower half
  localparam int INSTR_W  = 20;
  localparam int LEFT_HI  = 39;
  localparam int LEFT_LO  = 20;
  localparam int RIGHT_HI = 19;
  localparam int RIGHT_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } reader_state_e;

  function automatic logic [INSTR_W-1:0] left_instr(input logic [WORD_W-1:0] word);
    return word[LEFT_HI:LEFT_LO];
  endfunction

  function automatic logic [INSTR_W-1:0] right_instr(input logic [WORD_W-1:0] word);
    return word[RIGHT_HI:RIGHT_LO];
  endfunction

endpackage

// File: rtl/ias_byte_assembler.sv
// rtl/ias_byte_assembler.sv - 40-bit shift register that packs returned bytes into an IAS word
module ias_byte_assembler
  import ias_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out
);

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  // Bytes enter at the low end, so the first byte read ends up in the top lane
  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (shift_en) begin
      word_d = {word_q[WORD_W-BYTE_W-1:0], byte_in};
    end
  end

  // Assembly register
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_out = word_q;

endmodule

// File: rtl/ias_word_reader.sv
// rtl/ias_word_reader.sv - issues five byte reads per request and returns the assembled 40-bit word
module ias_word_reader
  import ias_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_word_addr,
  output logic [2:0]        mem_byte_sel,
  input  logic [7:0]        mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [39:0]       rsp_data
);

  reader_state_e     state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cap_q, cap_d;
  logic              req_hs;
  logic              rsp_hs;

  assign req_hs = req_valid & req_ready;
  assign rsp_hs = rsp_valid & rsp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one pass through the five lanes, one drain cycle, then hold until consumed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_hs) state_d = ISSUE;
      ISSUE:   if (lane_q == LAST_LANE) state_d = DRAIN;
      DRAIN:   state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; lane select is forced to 0 outside ISSUE so 5..7 never escape
  always_comb begin
    req_ready    = (state_q == IDLE) && !rst;
    mem_rd_en    = (state_q == ISSUE);
    mem_byte_sel = (state_q == ISSUE) ? lane_q : 3'd0;
    rsp_valid    = (state_q == RESP);
  end

  // Datapath next values: latched address, lane counter, and one-cycle-delayed capture strobe
  always_comb begin
    addr_d = addr_q;
    lane_d = lane_q;
    cap_d  = mem_rd_en;
    if (req_hs) begin
      addr_d = req_addr;
      lane_d = '0;
    end else if (state_q == ISSUE) begin
      lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      lane_q <= '0;
      cap_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      lane_q <= lane_d;
      cap_q  <= cap_d;
    end
  end

  assign mem_word_addr = addr_q;

  ias_byte_assembler u_assembler (
    .clk      (clk),
    .rst      (rst),
    .clr      (req_hs),
    .shift_en (cap_q),
    .byte_in  (mem_rdata),
    .word_out (rsp_data)
  );

endmodule

// File: tb/tb_ias_word_reader.sv
// tb/tb_ias_word_reader.sv - directed self-checking bench for ias_word_reader
module tb_ias_word_reader;
  import ias_pkg::*;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_word_addr;
  logic [2:0]        mem_byte_sel;
  logic [7:0]        mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [39:0]       rsp_data;

  logic [39:0] mem [0:4095];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [39:0] got;
  int          n_acc;
  int          n_rsp;
  int          acc_cyc [2];
  logic [39:0] rsp_seen [2];

  always #5 clk = ~clk;

  ias_word_reader #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_word_addr (mem_word_addr),
    .mem_byte_sel  (mem_byte_sel),
    .mem_rdata     (mem_rdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data)
  );

  function automatic logic [7:0] lane_byte(input logic [39:0] w, input logic [2:0] lane);
    logic [39:0] s;
    s = w << (8 * lane);
    return s[39:32];
  endfunction

  // Memory array with one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= lane_byte(mem[mem_word_addr], mem_byte_sel);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check("req_ready_idle", req_ready, 1);
  endtask

  task automatic read_word(input logic [ADDR_W-1:0] addr, input logic [39:0] exp,
                           input int hold, output logic [39:0] data);
    wait_idle();
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("issue_rd_en", mem_rd_en, 1);
      check("issue_byte_sel", mem_byte_sel, k);
      check("issue_word_addr", mem_word_addr, addr);
      check("issue_req_ready", req_ready, 0);
      @(negedge clk);
    end
    check("drain_rd_en", mem_rd_en, 0);
    check("drain_rsp_valid", rsp_valid, 0);
    rsp_ready = (hold == 0);
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, exp);
    check("rsp_req_ready", req_ready, 0);
    data = rsp_data;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, exp);
      check("hold_req_ready", req_ready, 0);
      if (i == hold) rsp_ready = 1'b1;
    end
    @(negedge clk);
    check("post_req_ready", req_ready, 1);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_rsp_data", rsp_data, exp);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    mem[12'h012] = 40'hA1B2C3D4E5;
    mem[12'h000] = 40'h0000000001;
    mem[12'hFFF] = 40'hFFFFFFFFFF;
    mem[12'h055] = 40'h5555555555;
    mem[12'h3A5] = 40'h8765412345;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_rd_en", mem_rd_en, 0);
    check("reset_word_addr", mem_word_addr, 0);
    check("reset_byte_sel", mem_byte_sel, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);

    // Single read, then the same read with four cycles of backpressure
    read_word(12'h012, 40'hA1B2C3D4E5, 0, got);
    read_word(12'h012, 40'hA1B2C3D4E5, 4, got);

    // Back-to-back with req_valid held high
    wait_idle();
    n_acc     = 0;
    n_rsp     = 0;
    req_addr  = 12'h000;
    req_valid = 1'b1;
    for (int c = 0; c < 40 && n_rsp < 2; c++) begin
      if (req_valid && req_ready && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (rsp_valid && rsp_ready && n_rsp < 2) begin
        rsp_seen[n_rsp] = rsp_data;
        n_rsp++;
      end
      @(negedge clk);
      if (n_acc == 1) req_addr = 12'hFFF;
      if (n_acc >= 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    check("b2b_accepts", n_acc, 2);
    check("b2b_responses", n_rsp, 2);
    check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 8);
    check("b2b_rsp0", rsp_seen[0], 40'h0000000001);
    check("b2b_rsp1", rsp_seen[1], 40'hFFFFFFFFFF);

    // Request pulsed while busy must be ignored
    wait_idle();
    req_valid = 1'b1;
    req_addr  = 12'h012;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 12'h055;
    check("busy_req_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_word_addr", mem_word_addr, 12'h012);
    n_rsp = 0;
    got   = '0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        got = rsp_data;
      end
      @(negedge clk);
    end
    check("busy_rsp_count", n_rsp, 1);
    check("busy_rsp_data", got, 40'hA1B2C3D4E5);
    check("busy_word_addr_end", mem_word_addr, 12'h012);

    // Reset asserted in T+3 of a read
    wait_idle();
    req_valid = 1'b1;
    req_addr  = 12'h3A5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_req_ready", req_ready, 0);
    @(negedge clk);
    check("abort_req_ready", req_ready, 0);
    check("abort_rd_en", mem_rd_en, 0);
    check("abort_word_addr", mem_word_addr, 0);
    check("abort_byte_sel", mem_byte_sel, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_data", rsp_data, 0);
    rst   = 1'b0;
    n_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) n_rsp++;
      @(negedge clk);
    end
    check("abort_no_rsp", n_rsp, 0);

    // Fresh read after abort, also exercising the instruction field split
    read_word(12'h3A5, 40'h8765412345, 1, got);
    check("left_field", left_instr(got), 20'h87654);
    check("right_field", right_instr(got), 20'h12345);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
